sd_card_monitor: RTL and testbench

- Avalon-MM slave controller for the SD socket's card-detect and write-protect switches.
- Synchronizes and debounces both switches, then sequences socket power through an insert/power-up/ready state machine.
- Latches insert, remove and write-protect-change events and raises a maskable interrupt.
- Sits between the raw socket pins and the SD host CPU; replaces bare PIO reads of the switches.

---
 rtl/sd_card_monitor_pkg.sv | 31 +++
 rtl/sd_card_monitor_debounce.sv | 50 +++++
 rtl/sd_card_monitor.sv | 167 ++++++++++++++++
 tb/tb_sd_card_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_monitor_pkg.sv
// Shared register map, bit positions and FSM encoding for the SD socket monitor.
package sd_card_monitor_pkg;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL  = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EVENT    = 2'd3;

  localparam int STATUS_PRESENT   = 0;
  localparam int STATUS_WP        = 1;
  localparam int STATUS_READY     = 2;
  localparam int STATUS_STATE_LSB = 3;

  localparam int CONTROL_AUTO_POWER = 0;
  localparam int CONTROL_FORCE_OFF  = 1;

  localparam int EVENT_INSERT    = 0;
  localparam int EVENT_REMOVE    = 1;
  localparam int EVENT_WP_CHANGE = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY   = 2'd0;
  localparam state_t ST_POWERUP = 2'd1;
  localparam state_t ST_READY   = 2'd2;
  localparam state_t ST_OFF     = 2'd3;

  function automatic logic isPowered(input state_t s);
    return (s == ST_POWERUP) || (s == ST_READY);
  endfunction

endpackage

// File: rtl/sd_card_monitor_debounce.sv
// Two-flop synchronizer followed by a stable-sample-count debouncer for one socket switch.
module sd_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_count;
  logic          w_accept;

  // rise/fall are combinational so the event lands on the same edge the level moves
  assign w_accept = (r_sync2 != r_level) && (r_count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_level <= RESET_LEVEL;
      r_count <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = w_accept & r_sync2;
  assign fall  = w_accept & ~r_sync2;

endmodule

// File: rtl/sd_card_monitor.sv
// Avalon-MM SD socket monitor: debounced card-detect/write-protect, power sequencing FSM,
// W1C event latch and maskable registered interrupt.
module sd_card_monitor
  import sd_card_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int POWER_DELAY     = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        card_detect_n,
  input  logic        write_protect,
  output logic        sd_power_en,
  output logic        card_ready,
  output logic        irq
);

  localparam int PW = $clog2(POWER_DELAY) + 1;
  localparam logic [PW-1:0] POWER_LAST = PW'(POWER_DELAY - 1);

  logic          w_cardPresentRaw;
  logic          w_present;
  logic          w_presentRise;
  logic          w_presentFall;
  logic          w_wp;
  logic          w_wpRise;
  logic          w_wpFall;
  logic          w_wrEn;
  logic [2:0]    w_eventSet;
  logic [2:0]    w_eventClear;
  logic [31:0]   w_readMux;
  logic          w_unusedWriteBits;
  state_t        w_nextState;

  state_t        r_state;
  logic [PW-1:0] r_powerCount;
  logic          r_powerEn;
  logic          r_cardReady;
  logic          r_autoPower;
  logic          r_forceOff;
  logic [2:0]    r_irqMask;
  logic [2:0]    r_event;
  logic          r_irq;
  logic [31:0]   r_readdata;

  assign w_cardPresentRaw  = ~card_detect_n;
  assign w_unusedWriteBits = ^writedata[31:3];

  sd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b0)
  ) u_presentDebounce (
    .clk  (clk),
    .reset(reset),
    .raw  (w_cardPresentRaw),
    .level(w_present),
    .rise (w_presentRise),
    .fall (w_presentFall)
  );

  // Write protect resets to 1 so an unknown socket is treated as protected
  sd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_wpDebounce (
    .clk  (clk),
    .reset(reset),
    .raw  (write_protect),
    .level(w_wp),
    .rise (w_wpRise),
    .fall (w_wpFall)
  );

  // Card removal outranks force_off when both apply in POWERUP/READY
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_EMPTY:   if (w_present && r_autoPower && !r_forceOff) w_nextState = ST_POWERUP;
      ST_POWERUP: begin
        if (!w_present)                     w_nextState = ST_EMPTY;
        else if (r_forceOff)                w_nextState = ST_OFF;
        else if (r_powerCount == POWER_LAST) w_nextState = ST_READY;
      end
      ST_READY: begin
        if (!w_present)      w_nextState = ST_EMPTY;
        else if (r_forceOff) w_nextState = ST_OFF;
      end
      ST_OFF:     if (!r_forceOff) w_nextState = ST_EMPTY;
      default:    w_nextState = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_powerCount <= '0;
      r_powerEn    <= 1'b0;
      r_cardReady  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_powerEn   <= isPowered(w_nextState);
      r_cardReady <= (w_nextState == ST_READY);
      if ((r_state == ST_POWERUP) && (w_nextState == ST_POWERUP))
        r_powerCount <= r_powerCount + 1'b1;
      else
        r_powerCount <= '0;
    end
  end

  assign w_wrEn       = chipselect & write;
  assign w_eventClear = (w_wrEn && (address == ADDR_EVENT)) ? writedata[2:0] : 3'b000;
  assign w_eventSet   = {w_wpRise | w_wpFall, w_presentFall, w_presentRise};

  // A new event outranks a W1C of the same bit in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_autoPower <= 1'b1;
      r_forceOff  <= 1'b0;
      r_irqMask   <= 3'b000;
      r_event     <= 3'b000;
      r_irq       <= 1'b0;
    end else begin
      if (w_wrEn && (address == ADDR_CONTROL)) begin
        r_autoPower <= writedata[CONTROL_AUTO_POWER];
        r_forceOff  <= writedata[CONTROL_FORCE_OFF];
      end
      if (w_wrEn && (address == ADDR_IRQ_MASK))
        r_irqMask <= writedata[2:0];
      r_event <= (r_event & ~w_eventClear) | w_eventSet;
      r_irq   <= |(r_event & r_irqMask);
    end
  end

  always_comb begin
    w_readMux = '0;
    case (address)
      ADDR_STATUS: begin
        w_readMux[STATUS_PRESENT]                 = w_present;
        w_readMux[STATUS_WP]                      = w_wp;
        w_readMux[STATUS_READY]                   = r_cardReady;
        w_readMux[STATUS_STATE_LSB +: 2]          = r_state;
      end
      ADDR_CONTROL: begin
        w_readMux[CONTROL_AUTO_POWER] = r_autoPower;
        w_readMux[CONTROL_FORCE_OFF]  = r_forceOff;
      end
      ADDR_IRQ_MASK: w_readMux[2:0] = r_irqMask;
      default:       w_readMux[2:0] = r_event;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_readMux;
  end

  assign readdata    = r_readdata;
  assign sd_power_en = r_powerEn;
  assign card_ready  = r_cardReady;
  assign irq         = r_irq;

endmodule

// File: tb/tb_sd_card_monitor.sv
// Bench for sd_card_monitor: register vector table, directed timing sequences and a
// randomized run checked against a window-based behavioural model.
module tb_sd_card_monitor;
  import sd_card_monitor_pkg::*;

  localparam int DC = 4;
  localparam int PD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        card_detect_n = 1'b1;
  logic        write_protect = 1'b1;
  logic        sd_power_en;
  logic        card_ready;
  logic        irq;

  always #5 clk = ~clk;

  sd_card_monitor #(.DEBOUNCE_CYCLES(DC), .POWER_DELAY(PD)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(readdata), .card_detect_n(card_detect_n),
    .write_protect(write_protect), .sd_power_en(sd_power_en), .card_ready(card_ready), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: debounced levels come from a sliding window over raw history
  bit         modelActive = 1'b0;
  int         mEdge, mEntry;
  logic       cdQ[$];
  logic       wpQ[$];
  logic       mPresent, mWp, mAuto, mForce, mIrq, mPower, mReady;
  logic [1:0] mState;
  logic [2:0] mMask, mEvent;
  logic [31:0] mRd;

  typedef struct {
    logic        doWrite;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expected;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    cdQ.delete(); wpQ.delete();
    for (int i = 0; i < DC + 2; i++) begin
      cdQ.push_back(1'b0);
      wpQ.push_back(1'b1);
    end
    mEdge = 0; mEntry = 0;
    mPresent = 1'b0; mWp = 1'b1; mAuto = 1'b1; mForce = 1'b0;
    mMask = 3'b0; mEvent = 3'b0; mIrq = 1'b0; mPower = 1'b0; mReady = 1'b0;
    mState = 2'd0; mRd = '0;
  endtask

  task automatic modelStep();
    logic nPresent, nWp, allDiff;
    logic [1:0] nState;
    logic [2:0] setBits, clrBits;
    logic [31:0] rd;
    mEdge++;
    cdQ.push_back(!card_detect_n);
    wpQ.push_back(write_protect);
    nPresent = mPresent;
    allDiff = 1'b1;
    for (int i = 0; i < DC; i++) if (cdQ[cdQ.size() - 3 - i] == mPresent) allDiff = 1'b0;
    if (allDiff) nPresent = !mPresent;
    nWp = mWp;
    allDiff = 1'b1;
    for (int i = 0; i < DC; i++) if (wpQ[wpQ.size() - 3 - i] == mWp) allDiff = 1'b0;
    if (allDiff) nWp = !mWp;
    while (cdQ.size() > DC + 3) void'(cdQ.pop_front());
    while (wpQ.size() > DC + 3) void'(wpQ.pop_front());

    case (address)
      2'd0:    rd = {27'b0, mState, (mState == 2'd2), mWp, mPresent};
      2'd1:    rd = {30'b0, mForce, mAuto};
      2'd2:    rd = {29'b0, mMask};
      default: rd = {29'b0, mEvent};
    endcase

    nState = mState;
    case (mState)
      2'd0: if (mPresent && mAuto && !mForce) begin nState = 2'd1; mEntry = mEdge; end
      2'd1: if (!mPresent) nState = 2'd0;
            else if (mForce) nState = 2'd3;
            else if (mEdge - mEntry == PD) nState = 2'd2;
      2'd2: if (!mPresent) nState = 2'd0;
            else if (mForce) nState = 2'd3;
      default: if (!mForce) nState = 2'd0;
    endcase

    clrBits = (chipselect && write && address == 2'd3) ? writedata[2:0] : 3'b0;
    setBits = {nWp != mWp, mPresent && !nPresent, !mPresent && nPresent};
    mIrq = |(mEvent & mMask);
    mEvent = (mEvent & ~clrBits) | setBits;
    if (chipselect && write && address == 2'd1) begin mAuto = writedata[0]; mForce = writedata[1]; end
    if (chipselect && write && address == 2'd2) mMask = writedata[2:0];
    mState = nState;
    mPower = (nState == 2'd1) || (nState == 2'd2);
    mReady = (nState == 2'd2);
    mRd = rd;
    mPresent = nPresent;
    mWp = nWp;
  endtask

  task automatic tick();
    if (modelActive) modelStep();
    @(posedge clk);
    #1;
    if (modelActive) begin
      checkOutput("rand readdata", readdata, mRd);
      checkOutput("rand sd_power_en", {31'b0, sd_power_en}, {31'b0, mPower});
      checkOutput("rand card_ready", {31'b0, card_ready}, {31'b0, mReady});
      checkOutput("rand irq", {31'b0, irq}, {31'b0, mIrq});
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] addr, input logic [31:0] data);
    chipselect = wr;
    write = wr;
    address = addr;
    writedata = data;
    tick();
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick();
    data = readdata;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  ra;
    int          op;

    repeat (3) tick();
    checkOutput("reset sd_power_en", {31'b0, sd_power_en}, 32'h0);
    checkOutput("reset card_ready", {31'b0, card_ready}, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'h0);
    checkOutput("reset readdata", readdata, 32'h0);
    reset = 1'b0;

    vecs.push_back(vec_t'{1'b0, ADDR_STATUS,   32'h0,        32'h2, "STATUS reset"});
    vecs.push_back(vec_t'{1'b0, ADDR_CONTROL,  32'h0,        32'h1, "CONTROL reset"});
    vecs.push_back(vec_t'{1'b0, ADDR_IRQ_MASK, 32'h0,        32'h0, "IRQ_MASK reset"});
    vecs.push_back(vec_t'{1'b0, ADDR_EVENT,    32'h0,        32'h0, "EVENT reset"});
    vecs.push_back(vec_t'{1'b1, ADDR_CONTROL,  32'hFFFFFFFC, 32'h0, "CONTROL wr 0"});
    vecs.push_back(vec_t'{1'b1, ADDR_CONTROL,  32'h00000002, 32'h2, "CONTROL wr force"});
    vecs.push_back(vec_t'{1'b1, ADDR_CONTROL,  32'h00000001, 32'h1, "CONTROL wr auto"});
    vecs.push_back(vec_t'{1'b1, ADDR_IRQ_MASK, 32'hFFFFFFFD, 32'h5, "IRQ_MASK wr"});
    vecs.push_back(vec_t'{1'b1, ADDR_IRQ_MASK, 32'h0,        32'h0, "IRQ_MASK clear"});
    vecs.push_back(vec_t'{1'b1, ADDR_STATUS,   32'hFFFFFFFF, 32'h2, "STATUS ro"});
    vecs.push_back(vec_t'{1'b1, ADDR_EVENT,    32'h7,        32'h0, "EVENT w1c idle"});
    foreach (vecs[i]) begin
      if (vecs[i].doWrite) applyStimulus(1'b1, vecs[i].addr, vecs[i].wdata);
      readReg(vecs[i].addr, rd);
      checkOutput(vecs[i].name, rd, vecs[i].expected);
    end

    // Insert with exact edge timing
    write_protect = 1'b0;
    repeat (10) tick();
    applyStimulus(1'b1, ADDR_EVENT, 32'h7);
    applyStimulus(1'b1, ADDR_IRQ_MASK, 32'h1);
    address = ADDR_STATUS;
    card_detect_n = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 6) begin
        checkOutput("insert status@6", readdata, 32'h0);
        checkOutput("insert irq@6", {31'b0, irq}, 32'h0);
        checkOutput("insert power@6", {31'b0, sd_power_en}, 32'h0);
      end
      if (e == 7) begin
        checkOutput("insert status@7", readdata, 32'h1);
        checkOutput("insert irq@7", {31'b0, irq}, 32'h1);
        checkOutput("insert power@7", {31'b0, sd_power_en}, 32'h1);
      end
      if (e == 14) checkOutput("insert ready@14", {31'b0, card_ready}, 32'h0);
      if (e == 15) checkOutput("insert ready@15", {31'b0, card_ready}, 32'h1);
      if (e == 16) checkOutput("insert status ready", readdata, 32'h15);
    end
    readReg(ADDR_EVENT, rd);
    checkOutput("insert event", rd, 32'h1);

    // Removal from READY
    applyStimulus(1'b1, ADDR_EVENT, 32'h1);
    applyStimulus(1'b1, ADDR_IRQ_MASK, 32'h3);
    card_detect_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) checkOutput("remove power@6", {31'b0, sd_power_en}, 32'h1);
      if (e == 7) begin
        checkOutput("remove power@7", {31'b0, sd_power_en}, 32'h0);
        checkOutput("remove ready@7", {31'b0, card_ready}, 32'h0);
      end
    end
    readReg(ADDR_STATUS, rd);
    checkOutput("remove status", rd, 32'h0);
    readReg(ADDR_EVENT, rd);
    checkOutput("remove event", rd, 32'h2);
    checkOutput("remove irq", {31'b0, irq}, 32'h1);
    applyStimulus(1'b1, ADDR_EVENT, 32'h2);
    checkOutput("w1c irq same edge", {31'b0, irq}, 32'h1);
    tick();
    checkOutput("w1c irq next edge", {31'b0, irq}, 32'h0);
    readReg(ADDR_EVENT, rd);
    checkOutput("w1c event", rd, 32'h0);

    // Bounce shorter than the debounce window
    card_detect_n = 1'b0;
    repeat (3) tick();
    card_detect_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checkOutput("bounce irq", {31'b0, irq}, 32'h0);
    end
    readReg(ADDR_STATUS, rd);
    checkOutput("bounce status", rd, 32'h0);
    readReg(ADDR_EVENT, rd);
    checkOutput("bounce event", rd, 32'h0);

    // force_off from READY and re-power
    card_detect_n = 1'b0;
    repeat (16) tick();
    checkOutput("force pre ready", {31'b0, card_ready}, 32'h1);
    applyStimulus(1'b1, ADDR_EVENT, 32'h7);
    applyStimulus(1'b1, ADDR_CONTROL, 32'h3);
    checkOutput("force power write edge", {31'b0, sd_power_en}, 32'h1);
    tick();
    checkOutput("force power off", {31'b0, sd_power_en}, 32'h0);
    readReg(ADDR_STATUS, rd);
    checkOutput("force status OFF", rd, 32'h19);
    applyStimulus(1'b1, ADDR_CONTROL, 32'h1);
    tick();
    checkOutput("unforce empty power", {31'b0, sd_power_en}, 32'h0);
    tick();
    checkOutput("unforce powerup power", {31'b0, sd_power_en}, 32'h1);
    repeat (7) tick();
    checkOutput("unforce ready early", {31'b0, card_ready}, 32'h0);
    tick();
    checkOutput("unforce ready", {31'b0, card_ready}, 32'h1);

    // wp_change set collides with W1C of the same bit
    write_protect = 1'b1;
    repeat (5) tick();
    applyStimulus(1'b1, ADDR_EVENT, 32'h4);
    readReg(ADDR_EVENT, rd);
    checkOutput("collision event", rd, 32'h4);
    applyStimulus(1'b1, ADDR_EVENT, 32'h4);
    readReg(ADDR_EVENT, rd);
    checkOutput("collision cleared", rd, 32'h0);

    // Reset in the middle of POWERUP
    applyStimulus(1'b1, ADDR_CONTROL, 32'h3);
    repeat (2) tick();
    applyStimulus(1'b1, ADDR_CONTROL, 32'h1);
    repeat (5) tick();
    checkOutput("midreset powerup", {31'b0, sd_power_en}, 32'h1);
    reset = 1'b1;
    tick();
    checkOutput("midreset power", {31'b0, sd_power_en}, 32'h0);
    checkOutput("midreset ready", {31'b0, card_ready}, 32'h0);
    checkOutput("midreset readdata", readdata, 32'h0);
    reset = 1'b0;
    readReg(ADDR_STATUS, rd);
    checkOutput("midreset status", rd, 32'h2);
    readReg(ADDR_CONTROL, rd);
    checkOutput("midreset control", rd, 32'h1);
    readReg(ADDR_IRQ_MASK, rd);
    checkOutput("midreset mask", rd, 32'h0);
    readReg(ADDR_EVENT, rd);
    checkOutput("midreset event", rd, 32'h0);

    // Randomized run against the behavioural model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelReset();
    modelActive = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 19) == 0) card_detect_n = ~card_detect_n;
      if ($urandom_range(0, 15) == 0) write_protect = ~write_protect;
      op = int'($urandom_range(0, 19));
      case (op)
        0: applyStimulus(1'b1, ADDR_EVENT, $urandom);
        1: applyStimulus(1'b1, ADDR_CONTROL,
                         {30'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0)});
        2: applyStimulus(1'b1, ADDR_IRQ_MASK, $urandom);
        default: begin
          ra = 2'($urandom_range(0, 3));
          applyStimulus(1'b0, ra, $urandom);
        end
      endcase
    end
    modelActive = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
